debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 127 ++++++++++++
 rtl/debounce_multi.sv | 60 ++++++
 tb/tb_debounce_multi.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types, default constants and threshold helper for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_e;

    localparam int unsigned DefClkFreq      = 100_000_000;
    localparam int unsigned DefStableTimeMs = 1;
    localparam int unsigned DefThr          = DefClkFreq / 1000 * DefStableTimeMs;

    // Wide enough for any practical counter width; callers cast to their own width.
    localparam int unsigned ThrW = 64;

    function automatic logic [ThrW-1:0] clamp_thr(input logic [ThrW-1:0] thr);
        return (thr == '0) ? ThrW'(1) : thr;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: input synchroniser, stability FSM/counter and edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CntWidth   = 24,
    parameter int unsigned SyncStages = 2,
    parameter logic        ResetVal   = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                sw_i,
    input  logic [CntWidth-1:0] thr_i,
    output logic                db_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                busy_o
);

    localparam deb_state_e          StRst  = ResetVal ? STABLE_HI : STABLE_LO;
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    logic [SyncStages-1:0] r_sync;
    logic                  w_sync;
    deb_state_e            r_state;
    deb_state_e            w_state_nxt;
    logic [CntWidth-1:0]   r_cnt;
    logic [CntWidth-1:0]   w_cnt_nxt;
    logic [CntWidth-1:0]   w_thr_m1;
    logic                  w_fast;
    logic                  r_rise;
    logic                  r_fall;
    logic                  w_rise_nxt;
    logic                  w_fall_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= {SyncStages{ResetVal}};
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], sw_i};
        end
    end

    assign w_sync   = r_sync[SyncStages-1];
    assign w_thr_m1 = thr_i - CntOne;
    // A threshold of one cycle commits straight from STABLE without a WAIT visit.
    assign w_fast   = (thr_i <= CntOne);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StRst;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_sync) begin
                    if (w_fast) begin
                        w_state_nxt = STABLE_HI;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_HI;
                        w_cnt_nxt   = CntOne;
                    end
                end
            end
            WAIT_HI: begin
                if (!w_sync) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= w_thr_m1) begin
                    // >= so a threshold lowered below the running count commits at once.
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end
            STABLE_HI: begin
                if (!w_sync) begin
                    if (w_fast) begin
                        w_state_nxt = STABLE_LO;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_LO;
                        w_cnt_nxt   = CntOne;
                    end
                end
            end
            WAIT_LO: begin
                if (w_sync) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= w_thr_m1) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end
            default: begin
                w_state_nxt = StRst;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign db_o   = (r_state == STABLE_HI) || (r_state == WAIT_LO);
    assign busy_o = (r_state == WAIT_HI) || (r_state == WAIT_LO);
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: shared runtime-programmable threshold feeding independent lanes.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned NumCh        = 4,
    parameter int unsigned CntWidth     = 24,
    parameter int unsigned ClkFreq      = DefClkFreq,
    parameter int unsigned StableTimeMs = DefStableTimeMs,
    parameter int unsigned DefaultThr   = ClkFreq / 1000 * StableTimeMs,
    parameter int unsigned SyncStages   = 2,
    parameter logic        ResetVal     = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumCh-1:0]    sw_i,
    input  logic [CntWidth-1:0] thr_i,
    input  logic                thr_load_i,
    output logic [NumCh-1:0]    db_o,
    output logic [NumCh-1:0]    rise_o,
    output logic [NumCh-1:0]    fall_o,
    output logic [NumCh-1:0]    busy_o,
    output logic [CntWidth-1:0] thr_o
);

    localparam logic [CntWidth-1:0] ThrRst = CntWidth'(clamp_thr(ThrW'(DefaultThr)));

    logic [CntWidth-1:0] r_thr;
    logic [CntWidth-1:0] w_thr_ld;

    // Clamp on the way in so the stored value is always the effective threshold.
    assign w_thr_ld = CntWidth'(clamp_thr(ThrW'(thr_i)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_thr <= ThrRst;
        end else if (thr_load_i) begin
            r_thr <= w_thr_ld;
        end
    end

    assign thr_o = r_thr;

    for (genvar g = 0; g < NumCh; g++) begin : g_ch
        debounce_channel #(
            .CntWidth   (CntWidth),
            .SyncStages (SyncStages),
            .ResetVal   (ResetVal)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .sw_i   (sw_i[g]),
            .thr_i  (r_thr),
            .db_o   (db_o[g]),
            .rise_o (rise_o[g]),
            .fall_o (fall_o[g]),
            .busy_o (busy_o[g])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random stimulus against a run-length model.
module tb_debounce_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw;
    logic [23:0] thr;
    logic        thr_load;
    logic [3:0]  db, rise, fall, busy;
    logic [23:0] thr_o;

    int checks = 0;
    int errors = 0;

    debounce_multi dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sw_i       (sw),
        .thr_i      (thr),
        .thr_load_i (thr_load),
        .db_o       (db),
        .rise_o     (rise),
        .fall_o     (fall),
        .busy_o     (busy),
        .thr_o      (thr_o)
    );

    always #5 clk = ~clk;

    // Model: sw seen two cycles late; db flips once the run of cycles where the
    // delayed input differs from db reaches the current threshold.
    logic [23:0] m_thr;
    logic [3:0]  m_d1, m_d2, m_db, m_rise, m_fall, m_busy;
    int          m_run [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_thr = 24'd100000;
            m_d1 = '0; m_d2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_busy = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (m_d2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= int'(m_thr)) begin
                        m_db[i]  = ~m_db[i];
                        m_run[i] = 0;
                        if (m_db[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_busy[i] = (m_run[i] != 0);
            end
            m_d2 = m_d1;
            m_d1 = sw;
            if (thr_load) m_thr = (thr == 24'd0) ? 24'd1 : thr;
        end
    end

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic load_thr(input logic [23:0] v);
        thr = v; thr_load = 1'b1;
        @(negedge clk);
        thr_load = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sw = 4'hF; thr = '0; thr_load = 1'b0;
        settle(3);
        checks += 5;
        if (db !== 4'h0)   begin errors++; $display("FAIL reset_db got=%h exp=0", db); end
        if (rise !== 4'h0) begin errors++; $display("FAIL reset_rise got=%h exp=0", rise); end
        if (fall !== 4'h0) begin errors++; $display("FAIL reset_fall got=%h exp=0", fall); end
        if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
        if (thr_o !== 24'd100000) begin errors++; $display("FAIL reset_thr got=%0d exp=100000", thr_o); end
        rst_n = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            checks++;
            if (db !== m_db || rise !== m_rise || fall !== m_fall || busy !== m_busy || thr_o !== m_thr) begin
                errors++;
                $display("FAIL reset_run c=%0d db=%b/%b rise=%b/%b fall=%b/%b busy=%b/%b thr=%0d/%0d",
                         c, db, m_db, rise, m_rise, fall, m_fall, busy, m_busy, thr_o, m_thr);
            end
        end
        checks++;
        if (busy !== 4'hF) begin errors++; $display("FAIL reset_busy_wait got=%h exp=f", busy); end
        // Counts are far past 19, so lowering THR to 20 must commit on the following edge.
        load_thr(24'd20);
        checks += 2;
        if (db !== 4'h0 || thr_o !== 24'd20) begin errors++; $display("FAIL reset_lower_pre db=%h thr=%0d exp db=0 thr=20", db, thr_o); end
        @(negedge clk);
        if (db !== 4'hF || rise !== 4'hF) begin errors++; $display("FAIL reset_lower_commit db=%h rise=%h exp f f", db, rise); end
        sw = 4'h0;
        settle(30);
    endtask

    task automatic test_clean_step;
        load_thr(24'd4);
        sw = 4'h0;
        settle(10);
        sw[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks += 2;
            if (db[0] !== (c >= 6) || rise[0] !== (c == 6) || fall[0] !== 1'b0 || busy[0] !== (c >= 3 && c <= 5)) begin
                errors++;
                $display("FAIL clean_step c=%0d db=%b rise=%b fall=%b busy=%b", c, db[0], rise[0], fall[0], busy[0]);
            end
            if (db !== m_db || rise !== m_rise || fall !== m_fall || busy !== m_busy || thr_o !== m_thr) begin
                errors++;
                $display("FAIL clean_model c=%0d db=%b/%b rise=%b/%b fall=%b/%b busy=%b/%b", c, db, m_db, rise, m_rise, fall, m_fall, busy, m_busy);
            end
        end
        sw = 4'h0;
        settle(10);
    endtask

    task automatic test_bounce;
        int rises = 0, falls = 0, rise_c = -1;
        for (int k = 0; k < 50; k++) begin
            for (int c = 0; c < 5; c++) begin
                sw[1] = (c < 3);
                @(negedge clk);
                rises += int'(rise[1]); falls += int'(fall[1]);
                checks++;
                if (db !== m_db || rise !== m_rise || fall !== m_fall || busy !== m_busy) begin
                    errors++;
                    $display("FAIL bounce_model k=%0d db=%b/%b rise=%b/%b busy=%b/%b", k, db, m_db, rise, m_rise, busy, m_busy);
                end
            end
        end
        sw[1] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            rises += int'(rise[1]); falls += int'(fall[1]);
            if (db[1] === 1'b1 && rise_c < 0) rise_c = c;
        end
        checks += 3;
        if (rises != 1) begin errors++; $display("FAIL bounce_rises got=%0d exp=1", rises); end
        if (falls != 0) begin errors++; $display("FAIL bounce_falls got=%0d exp=0", falls); end
        if (rise_c != 6) begin errors++; $display("FAIL bounce_latency got=%0d exp=6", rise_c); end
        sw = 4'h0;
        settle(10);
    endtask

    task automatic test_independence;
        int pair_c = -1;
        logic db2_seen = 1'b0;
        sw = 4'b1110;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) sw[2] = 1'b0;
            if (rise[1] === 1'b1 && rise[3] === 1'b1) pair_c = c;
            if (db[2] !== 1'b0) db2_seen = 1'b1;
            checks++;
            if (db !== m_db || rise !== m_rise || fall !== m_fall || busy !== m_busy) begin
                errors++;
                $display("FAIL indep_model c=%0d db=%b/%b rise=%b/%b busy=%b/%b", c, db, m_db, rise, m_rise, busy, m_busy);
            end
        end
        checks += 2;
        if (pair_c != 6) begin errors++; $display("FAIL indep_pair got=%0d exp=6", pair_c); end
        if (db2_seen) begin errors++; $display("FAIL indep_glitch db2 got=1 exp=0"); end
        sw = 4'h0;
        settle(10);
    endtask

    task automatic test_thr_edges;
        int c0 = -1, c2 = -1;
        load_thr(24'd0);
        checks++;
        if (thr_o !== 24'd1) begin errors++; $display("FAIL thr_zero got=%0d exp=1", thr_o); end
        sw[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (db[0] === 1'b1 && c0 < 0) c0 = c;
        end
        checks++;
        if (c0 != 3) begin errors++; $display("FAIL thr_one_latency got=%0d exp=3", c0); end
        sw = 4'h0;
        settle(5);
        load_thr(24'd10);
        settle(3);
        sw[2] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (db[2] === 1'b1 && c2 < 0) c2 = c;
            checks++;
            if (db !== m_db || rise !== m_rise || fall !== m_fall || busy !== m_busy || thr_o !== m_thr) begin
                errors++;
                $display("FAIL thr_model c=%0d db=%b/%b busy=%b/%b thr=%0d/%0d", c, db, m_db, busy, m_busy, thr_o, m_thr);
            end
            thr_load = 1'b0;
            if (c == 8) begin thr = 24'd3; thr_load = 1'b1; end
        end
        checks++;
        if (c2 != 10) begin errors++; $display("FAIL thr_lower_commit got=%0d exp=10", c2); end
        sw = 4'h0;
        settle(6);
    endtask

    task automatic test_random;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            checks++;
            if (db !== m_db || rise !== m_rise || fall !== m_fall || busy !== m_busy || thr_o !== m_thr) begin
                errors++;
                $display("FAIL random c=%0d db=%b/%b rise=%b/%b fall=%b/%b busy=%b/%b thr=%0d/%0d",
                         c, db, m_db, rise, m_rise, fall, m_fall, busy, m_busy, thr_o, m_thr);
            end
            for (int i = 0; i < 4; i++)
                if ($urandom_range(5) == 0) sw[i] = ~sw[i];
            thr_load = ($urandom_range(40) == 0);
            thr = 24'($urandom_range(6));
        end
        thr_load = 1'b0;
        sw = 4'h0;
        settle(12);
    endtask

    task automatic test_midcount_reset;
        int rises = 0;
        load_thr(24'd8);
        sw = 4'b0001;
        settle(15);
        sw = 4'b1001;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        checks++;
        if (busy[3] !== 1'b1 || db[0] !== 1'b1) begin errors++; $display("FAIL midrst_pre busy3=%b db0=%b exp 1 1", busy[3], db[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (db !== 4'h0)   begin errors++; $display("FAIL midrst_db got=%h exp=0", db); end
        if (busy !== 4'h0) begin errors++; $display("FAIL midrst_busy got=%h exp=0", busy); end
        if (rise !== 4'h0 || fall !== 4'h0) begin errors++; $display("FAIL midrst_pulse rise=%h fall=%h exp 0", rise, fall); end
        if (thr_o !== 24'd100000) begin errors++; $display("FAIL midrst_thr got=%0d exp=100000", thr_o); end
        sw = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            rises += int'(|rise);
            checks++;
            if (db !== m_db || rise !== m_rise || fall !== m_fall || busy !== m_busy || thr_o !== m_thr) begin
                errors++;
                $display("FAIL midrst_model c=%0d db=%b/%b rise=%b/%b busy=%b/%b", c, db, m_db, rise, m_rise, busy, m_busy);
            end
        end
        checks++;
        if (rises != 0) begin errors++; $display("FAIL midrst_rise got=%0d exp=0", rises); end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_independence();
        test_thr_edges();
        test_random();
        test_midcount_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
